// File: rtl/spart_pkg.sv
// Shared SPART definitions: receiver state encoding, oversampling default
// and the bus register map used by the SPART bus interface.
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int OVERSAMPLE_DEF = 16;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

endpackage

// File: rtl/spart_baud_gen.sv
// Oversample tick generator: counts 0..divisor and pulses o_tick on the
// terminal count. i_clear realigns the count to a detected start edge.
module spart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic [DIV_W-1:0] i_divisor,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == i_divisor);
    assign o_tick = w_wrap;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: 8N1 serial input oversampled by OVERSAMPLE, LSB-first
// assembly, and a one-deep holding register with rda/framing/overrun flags.
module spart_rx
    import spart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic [DIV_W-1:0]     divisor,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 frm_err,
    output logic                 ovr_err
);

    localparam int SUB_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS) + 1;
    localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    rx_state_e             r_state;
    logic                  r_rxd_meta;
    logic                  r_rxd_s;
    logic                  r_rxd_d;
    logic [SUB_W-1:0]      r_sub;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_stop_bit;
    logic                  r_load;
    logic                  w_fall;
    logic                  w_clear;
    logic                  w_tick;

    assign w_fall  = r_rxd_d & ~r_rxd_s;
    assign w_clear = (r_state == IDLE) && w_fall;

    spart_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clear   (w_clear),
        .i_divisor (divisor),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
            r_rxd_d    <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_s    <= r_rxd_meta;
            r_rxd_d    <= r_rxd_s;
        end
    end

    // The stop sample is taken one cycle before the holding register loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sub      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_stop_bit <= 1'b1;
            r_load     <= 1'b0;
            rx_data    <= '0;
            rda        <= 1'b0;
            frm_err    <= 1'b0;
            ovr_err    <= 1'b0;
        end else begin
            r_load <= 1'b0;

            if (r_load) begin
                rx_data <= r_shift;
                rda     <= 1'b1;
                frm_err <= ~r_stop_bit;
                ovr_err <= rda & ~rd_ack;
            end else if (rd_ack && rda) begin
                rda     <= 1'b0;
                frm_err <= 1'b0;
                ovr_err <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_sub   <= '0;
                        r_bit   <= '0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_sub == SUB_HALF) begin
                            r_sub <= '0;
                            r_bit <= '0;
                            r_state <= r_rxd_s ? IDLE : DATA;
                        end else begin
                            r_sub <= r_sub + SUB_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_sub <= r_sub + SUB_W'(1);
                        if (r_sub == SUB_LAST) begin
                            r_shift <= {r_rxd_s, r_shift[DATA_BITS-1:1]};
                            r_bit   <= r_bit + BIT_W'(1);
                            if (r_bit == BIT_LAST) begin
                                r_state <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (r_load) begin
                        r_state <= IDLE;
                    end else if (w_tick) begin
                        r_sub <= r_sub + SUB_W'(1);
                        if (r_sub == SUB_LAST) begin
                            r_stop_bit <= r_rxd_s;
                            r_load     <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx at divisor=0 (one tick per clock, 16-clock bits).
// Frames are driven one clock at a time so rd_ack and rst can land on exact cycles.
module tb_spart_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic [15:0] divisor;
    logic        rd_ack;
    logic [7:0]  rx_data;
    logic        rda;
    logic        frm_err;
    logic        ovr_err;

    int          checks = 0;
    int          errors = 0;
    int          firstRda;
    logic [7:0]  snapData;
    logic        snapRda;
    logic        snapFrm;
    logic        snapOvr;

    always #5 clk = ~clk;

    spart_rx dut (
        .clk     (clk),
        .rst     (rst),
        .rxd     (rxd),
        .divisor (divisor),
        .rd_ack  (rd_ack),
        .rx_data (rx_data),
        .rda     (rda),
        .frm_err (frm_err),
        .ovr_err (ovr_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseAck();
        rd_ack = 1'b1;
        @(posedge clk);
        #1;
        rd_ack = 1'b0;
    endtask

    // Iteration c drives the pin just after posedge c; the line is left at the stop level.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input int ackAt, input int rstAt);
        logic [9:0] frame;
        frame    = {stopBit, data, 1'b0};
        firstRda = -1;
        for (int c = 0; c < 160; c++) begin
            if (firstRda < 0 && rda === 1'b1) firstRda = c;
            if (c == rstAt + 1) begin
                snapData = rx_data;
                snapRda  = rda;
                snapFrm  = frm_err;
                snapOvr  = ovr_err;
            end
            rxd    = frame[c / 16];
            rd_ack = (c == ackAt);
            rst    = (c == rstAt);
            @(posedge clk);
            #1;
        end
        rd_ack = 1'b0;
        rst    = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        rxd     = 1'b1;
        rd_ack  = 1'b0;
        divisor = 16'd0;
        idleCycles(3);
        checkOutput("reset_rx_data", 32'(rx_data), 32'h00);
        checkOutput("reset_rda", 32'(rda), 32'd0);
        checkOutput("reset_frm_err", 32'(frm_err), 32'd0);
        checkOutput("reset_ovr_err", 32'(ovr_err), 32'd0);
        rst = 1'b0;
        idleCycles(5);

        $display("[TB] byte 0xA5, good stop");
        applyStimulus(8'hA5, 1'b1, -10, -10);
        idleCycles(4);
        checkOutput("t1_rx_data", 32'(rx_data), 32'hA5);
        checkOutput("t1_rda", 32'(rda), 32'd1);
        checkOutput("t1_frm_err", 32'(frm_err), 32'd0);
        checkOutput("t1_ovr_err", 32'(ovr_err), 32'd0);
        checkOutput("t1_rda_latency", 32'(firstRda), 32'd156);
        pulseAck();
        checkOutput("t1_rda_after_ack", 32'(rda), 32'd0);
        checkOutput("t1_rx_data_after_ack", 32'(rx_data), 32'hA5);

        $display("[TB] 3-cycle glitch");
        rxd = 1'b0;
        idleCycles(3);
        rxd = 1'b1;
        idleCycles(40);
        checkOutput("t2_rda", 32'(rda), 32'd0);
        checkOutput("t2_frm_err", 32'(frm_err), 32'd0);
        checkOutput("t2_ovr_err", 32'(ovr_err), 32'd0);

        $display("[TB] byte 0x3C, stop held low");
        applyStimulus(8'h3C, 1'b0, -10, -10);
        idleCycles(100);
        checkOutput("t3_rx_data", 32'(rx_data), 32'h3C);
        checkOutput("t3_rda", 32'(rda), 32'd1);
        checkOutput("t3_frm_err", 32'(frm_err), 32'd1);
        checkOutput("t3_ovr_err_line_low", 32'(ovr_err), 32'd0);
        rxd = 1'b1;
        idleCycles(20);
        checkOutput("t3_ovr_err_line_high", 32'(ovr_err), 32'd0);
        pulseAck();
        checkOutput("t3_rda_after_ack", 32'(rda), 32'd0);
        checkOutput("t3_frm_err_after_ack", 32'(frm_err), 32'd0);
        idleCycles(10);

        $display("[TB] overrun 0x11 then 0x22");
        applyStimulus(8'h11, 1'b1, -10, -10);
        idleCycles(10);
        checkOutput("t4_first_rx_data", 32'(rx_data), 32'h11);
        applyStimulus(8'h22, 1'b1, -10, -10);
        idleCycles(10);
        checkOutput("t4_rx_data", 32'(rx_data), 32'h22);
        checkOutput("t4_rda", 32'(rda), 32'd1);
        checkOutput("t4_ovr_err", 32'(ovr_err), 32'd1);
        checkOutput("t4_frm_err", 32'(frm_err), 32'd0);
        pulseAck();
        checkOutput("t4_rda_after_ack", 32'(rda), 32'd0);
        checkOutput("t4_ovr_err_after_ack", 32'(ovr_err), 32'd0);
        idleCycles(10);

        $display("[TB] rd_ack on load cycle of 0x7E");
        applyStimulus(8'h55, 1'b1, -10, -10);
        idleCycles(10);
        applyStimulus(8'h7E, 1'b1, 155, -10);
        idleCycles(4);
        checkOutput("t5_rda", 32'(rda), 32'd1);
        checkOutput("t5_ovr_err", 32'(ovr_err), 32'd0);
        checkOutput("t5_rx_data", 32'(rx_data), 32'h7E);
        checkOutput("t5_frm_err", 32'(frm_err), 32'd0);
        idleCycles(10);

        $display("[TB] reset mid-frame, then 0x0F");
        applyStimulus(8'hFF, 1'b1, -10, 60);
        checkOutput("t6_rst_rx_data", 32'(snapData), 32'h00);
        checkOutput("t6_rst_rda", 32'(snapRda), 32'd0);
        checkOutput("t6_rst_frm_err", 32'(snapFrm), 32'd0);
        checkOutput("t6_rst_ovr_err", 32'(snapOvr), 32'd0);
        checkOutput("t6_no_stray_byte", 32'(rda), 32'd0);
        idleCycles(20);
        applyStimulus(8'h0F, 1'b1, -10, -10);
        idleCycles(4);
        checkOutput("t6_rx_data", 32'(rx_data), 32'h0F);
        checkOutput("t6_rda", 32'(rda), 32'd1);
        checkOutput("t6_frm_err", 32'(frm_err), 32'd0);
        checkOutput("t6_ovr_err", 32'(ovr_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
